fifo_drain_arbiter: RTL and testbench

- Round-robin scheduler that shares one output stream among NCH per-channel sample FIFOs (fifo, wbits=WBITS) in the 32-channel imitator.
- Grants one non-empty channel at a time and drains a burst of up to BURST words.
- Issues single-cycle rd pulses to the granted FIFO and forwards its dataOut on a valid/ready stream with sop/eop framing and the channel id.

---
 rtl/fifo_drain_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_drain_arbiter
//
// Round-robin scheduler that shares one valid/ready output stream among NCH
// per-channel sample FIFOs. One non-empty channel is granted at a time and a
// burst of up to BURST words is drained from it. Each word costs three
// cycles: RD (single-cycle read strobe), WAIT (FIFO dataOut settles after the
// read edge and is captured) and OUT (word held until accepted).
//
// Parameters:
//   NCH   - number of channel FIFOs (2..32)
//   WBITS - FIFO word width
//   BURST - maximum words per grant (1..65535)
//   CHW   - width of the channel id output (2**CHW >= NCH)
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous, active-high reset
//   fifo_empty - per-channel empty flags
//   fifo_cnt   - per-channel fill counts, 16 bits each, channel i at [16i +: 16]
//   fifo_dout  - per-channel dataOut, channel i at [WBITS*i +: WBITS]
//   fifo_rd    - one-hot read strobe to the granted FIFO
//   out_data   - output word
//   out_valid  - out_data valid
//   out_ready  - downstream accepts the word when out_valid && out_ready
//   out_sop    - first word of a burst
//   out_eop    - last word of a burst
//   out_ch     - channel id of the current burst
//   abort      - one-cycle pulse when a burst ends early on underrun
//   busy       - high in every state except IDLE
//
// Optional feature (compile-time macro FIFO_ARB_PRIO0_EN):
//   When defined, channel 0 has strict priority over all other channels and
//   its bursts leave the round-robin pointer untouched. When undefined, the
//   arbiter is pure round-robin over all NCH channels.
// -----------------------------------------------------------------------------
module fifo_drain_arbiter #(
    parameter int NCH   = 4,
    parameter int WBITS = 8,
    parameter int BURST = 16,
    parameter int CHW   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         fifo_empty,
    input  logic [16*NCH-1:0]      fifo_cnt,
    input  logic [WBITS*NCH-1:0]   fifo_dout,
    output logic [NCH-1:0]         fifo_rd,
    output logic [WBITS-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [CHW-1:0]         out_ch,
    output logic                   abort,
    output logic                   busy
);

    // Per-channel inputs are spread over a power-of-two table so that a
    // CHW-bit channel id indexes it directly; unused slots read as empty.
    localparam int NSLOT = 1 << CHW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [15:0]    BURST_W = 16'(BURST);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

    logic [1:0]       state_reg;
    logic [CHW-1:0]   rr_ptr_reg;
    logic [CHW-1:0]   ch_reg;
    logic [15:0]      remaining_reg;
    logic             first_reg;
    logic [WBITS-1:0] out_data_reg;
    logic             out_valid_reg;
    logic             out_sop_reg;
    logic             out_eop_reg;
    logic             abort_reg;

    logic [NSLOT-1:0] empty_slot;
    logic [15:0]      cnt_slot  [NSLOT];
    logic [WBITS-1:0] dout_slot [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NCH) begin : g_real
                assign empty_slot[gi] = fifo_empty[gi];
                assign cnt_slot[gi]   = fifo_cnt[16*gi +: 16];
                assign dout_slot[gi]  = fifo_dout[WBITS*gi +: WBITS];
            end else begin : g_pad
                assign empty_slot[gi] = 1'b1;
                assign cnt_slot[gi]   = 16'd0;
                assign dout_slot[gi]  = '0;
            end
        end
    endgenerate

    // Grant search: first non-empty channel after rr_ptr, wrapping at NCH.
    logic           grant_found;
    logic [CHW-1:0] grant_ch;
    int             idx;

    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        idx         = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!grant_found && !empty_slot[idx[CHW-1:0]]) begin
                grant_found = 1'b1;
                grant_ch    = idx[CHW-1:0];
            end
        end
`ifdef FIFO_ARB_PRIO0_EN
        if (!empty_slot[0]) begin
            grant_found = 1'b1;
            grant_ch    = '0;
        end
`endif
    end

    // Burst length = min(count, BURST); a zero count on a non-empty FIFO
    // still holds at least one word.
    logic [15:0] grant_cnt;
    logic [15:0] grant_len;

    always_comb begin
        grant_cnt = cnt_slot[grant_ch];
        if (grant_cnt == 16'd0) begin
            grant_len = 16'd1;
        end else if (grant_cnt > BURST_W) begin
            grant_len = BURST_W;
        end else begin
            grant_len = grant_cnt;
        end
    end

    // Channel-0 bursts do not advance the pointer when channel 0 is the
    // priority channel, so the other channels keep their rotation.
    logic rr_hold;
`ifdef FIFO_ARB_PRIO0_EN
    assign rr_hold = (ch_reg == '0);
`else
    assign rr_hold = 1'b0;
`endif

    // The read strobe is combinational so an underrun seen in RD suppresses
    // it in the same cycle.
    logic rd_en;
    assign rd_en = (state_reg == S_RD) && !empty_slot[ch_reg];

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_rd
            assign fifo_rd[gi] = rd_en && (ch_reg == CHW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= LAST_CH;
            ch_reg        <= '0;
            remaining_reg <= 16'd0;
            first_reg     <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            abort_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (grant_found) begin
                        ch_reg        <= grant_ch;
                        remaining_reg <= grant_len;
                        first_reg     <= 1'b1;
                        state_reg     <= S_RD;
                    end
                end
                S_RD: begin
                    if (empty_slot[ch_reg]) begin
                        abort_reg <= 1'b1;
                        if (!rr_hold) begin
                            rr_ptr_reg <= ch_reg;
                        end
                        state_reg <= S_IDLE;
                    end else begin
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    out_data_reg  <= dout_slot[ch_reg];
                    out_valid_reg <= 1'b1;
                    out_sop_reg   <= first_reg;
                    out_eop_reg   <= (remaining_reg == 16'd1);
                    first_reg     <= 1'b0;
                    state_reg     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_sop_reg   <= 1'b0;
                        out_eop_reg   <= 1'b0;
                        remaining_reg <= remaining_reg - 16'd1;
                        if (out_eop_reg) begin
                            if (!rr_hold) begin
                                rr_ptr_reg <= ch_reg;
                            end
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg <= S_RD;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_sop   = out_sop_reg;
    assign out_eop   = out_eop_reg;
    assign out_ch    = ch_reg;
    assign abort     = abort_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_arbiter
//
// Directed bench for fifo_drain_arbiter (NCH=4, WBITS=8, BURST=16, CHW=5).
// Four behavioural FIFOs update their dataOut on the read edge. A negedge
// monitor logs every accepted word and counts read strobes, abort pulses,
// strobe/valid overlaps and idle gaps. Expected bursts are hand-listed.
// -----------------------------------------------------------------------------
module tb_fifo_drain_arbiter;

    localparam int NCH   = 4;
    localparam int WBITS = 8;
    localparam int BURST = 16;
    localparam int CHW   = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NCH-1:0]       fifo_empty;
    logic [16*NCH-1:0]    fifo_cnt;
    logic [WBITS*NCH-1:0] fifo_dout;
    logic [NCH-1:0]       fifo_rd;
    logic [WBITS-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sop;
    logic                 out_eop;
    logic [CHW-1:0]       out_ch;
    logic                 abort;
    logic                 busy;

    always #5 clk = ~clk;

    fifo_drain_arbiter #(
        .NCH   (NCH),
        .WBITS (WBITS),
        .BURST (BURST),
        .CHW   (CHW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_cnt   (fifo_cnt),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_ch     (out_ch),
        .abort      (abort),
        .busy       (busy)
    );

    // ---------------- FIFO models ----------------
    logic [7:0]     mem [NCH][64];
    int             wr_ptr [NCH];
    int             rd_ptr [NCH];
    logic [7:0]     dout_q [NCH];
    logic [NCH-1:0] force_empty;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                rd_ptr[c] <= 0;
                dout_q[c] <= 8'h00;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (fifo_rd[c]) begin
                    dout_q[c] <= mem[c][rd_ptr[c] % 64];
                    rd_ptr[c] <= rd_ptr[c] + 1;
                end
            end
        end
    end

    always_comb begin
        fifo_empty = '0;
        fifo_cnt   = '0;
        fifo_dout  = '0;
        for (int c = 0; c < NCH; c++) begin
            fifo_empty[c]          = (wr_ptr[c] == rd_ptr[c]) || force_empty[c];
            fifo_cnt[16*c +: 16]   = 16'(wr_ptr[c] - rd_ptr[c]);
            fifo_dout[8*c +: 8]    = dout_q[c];
        end
    end

    // ---------------- monitor ----------------
    int         mon_n = 0;
    logic [7:0] mon_data [256];
    int         mon_ch   [256];
    logic       mon_sop  [256];
    logic       mon_eop  [256];
    int         mon_rd   [NCH];
    int         n_abort  = 0;
    int         n_viol   = 0;
    int         n_gap    = 0;
    int         idle_run = 0;

    initial begin
        for (int c = 0; c < NCH; c++) mon_rd[c] = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            idle_run = 0;
        end else begin
            if (out_valid && out_ready && mon_n < 256) begin
                mon_data[mon_n] = out_data;
                mon_ch[mon_n]   = int'(out_ch);
                mon_sop[mon_n]  = out_sop;
                mon_eop[mon_n]  = out_eop;
                $display("[TB] word %0d ch=%0d data=0x%02h sop=%0b eop=%0b",
                         mon_n, out_ch, out_data, out_sop, out_eop);
                mon_n = mon_n + 1;
            end
            for (int c = 0; c < NCH; c++) begin
                if (fifo_rd[c]) mon_rd[c] = mon_rd[c] + 1;
            end
            if (abort) n_abort = n_abort + 1;
            if ($countones(fifo_rd) > 1 || (fifo_rd != '0 && out_valid)) n_viol = n_viol + 1;
            if (!busy && fifo_empty != {NCH{1'b1}}) begin
                idle_run = idle_run + 1;
                if (idle_run > 1) n_gap = n_gap + 1;
            end else begin
                idle_run = 0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int exp_idx = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int ch, input int data);
        mem[ch][wr_ptr[ch] % 64] = 8'(data);
        wr_ptr[ch] = wr_ptr[ch] + 1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        force_empty = '0;
        out_ready   = 1'b1;
        for (int c = 0; c < NCH; c++) wr_ptr[c] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_words(input int target);
        for (int i = 0; i < 600 && mon_n < target; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1 chk("word_count", mon_n, target);
    endtask

    task automatic expect_burst(input int ch, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("w%0d.ch", exp_idx), mon_ch[exp_idx], ch);
            chk($sformatf("w%0d.data", exp_idx), mon_data[exp_idx], (first + i) & 8'hFF);
            chk($sformatf("w%0d.sop", exp_idx), mon_sop[exp_idx], (i == 0));
            chk($sformatf("w%0d.eop", exp_idx), mon_eop[exp_idx], (i == n - 1));
            exp_idx++;
        end
    endtask

    // ---------------- stimulus ----------------
    int   base;
    int   rd_base;
    logic stable;
    logic [7:0] snap_d;
    logic snap_s, snap_e;
    int   grant_exp [4];
    int   grant_ch;

    initial begin
        out_ready   = 1'b1;
        force_empty = '0;
        for (int c = 0; c < NCH; c++) wr_ptr[c] = 0;

        // Reset state
        do_reset();
        chk("rst.valid", out_valid, 0);
        chk("rst.busy",  busy,      0);
        chk("rst.rd",    fifo_rd,   0);
        chk("rst.abort", abort,     0);
        chk("rst.sop",   out_sop,   0);
        chk("rst.eop",   out_eop,   0);
        chk("rst.ch",    out_ch,    0);
        chk("rst.data",  out_data,  0);

        // Single channel: ch2, 5 words, latency 3 edges from the grant cycle
        base = mon_n; exp_idx = base; rd_base = mon_rd[2];
        for (int i = 0; i < 5; i++) push(2, 8'h11 + i);
        repeat (2) @(posedge clk);
        #1 chk("t1.valid_early", out_valid, 0);
        @(posedge clk);
        #1 chk("t1.valid_lat3", out_valid, 1);
        chk("t1.first_data", out_data, 8'h11);
        chk("t1.first_ch", out_ch, 2);
        wait_words(base + 5);
        expect_burst(2, 8'h11, 5);
        chk("t1.rd2_pulses", mon_rd[2] - rd_base, 5);
        chk("t1.busy_end", busy, 0);

        // Burst cap and re-grant order: ch0 20 words, ch1 3, ch3 1
        do_reset();
        base = mon_n; exp_idx = base;
        for (int i = 0; i < 20; i++) push(0, 8'h40 + i);
        for (int i = 0; i < 3; i++)  push(1, 8'h80 + i);
        push(3, 8'hC0);
        wait_words(base + 24);
        expect_burst(0, 8'h40, 16);
        expect_burst(1, 8'h80, 3);
        expect_burst(3, 8'hC0, 1);
        expect_burst(0, 8'h50, 4);

        // Round-robin: all channels 2 words each -> order 0,1,2,3
        do_reset();
        base = mon_n; exp_idx = base;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 2; i++) push(c, 8'hA0 + c * 2 + i);
        wait_words(base + 8);
        for (int c = 0; c < NCH; c++) expect_burst(c, 8'hA0 + c * 2, 2);

        // Backpressure on word 2 of a ch1 burst
        do_reset();
        base = mon_n; exp_idx = base;
        for (int i = 0; i < 4; i++) push(1, 8'h21 + i);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && out_sop) break;
        end
        chk("t4.sop_seen", out_valid && out_sop, 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("t4.word2_valid", out_valid, 1);
        snap_d = out_data; snap_s = out_sop; snap_e = out_eop;
        rd_base = mon_rd[1];
        stable = 1'b1;
        repeat (7) begin
            @(negedge clk);
            if (out_data !== snap_d || out_sop !== snap_s || out_eop !== snap_e || !out_valid)
                stable = 1'b0;
        end
        chk("t4.stable", stable, 1);
        chk("t4.rd_in_stall", mon_rd[1] - rd_base, 0);
        chk("t4.word2_data", snap_d, 8'h22);
        chk("t4.word2_sop", snap_s, 0);
        chk("t4.word2_eop", snap_e, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_words(base + 4);
        expect_burst(1, 8'h21, 4);

        // Underrun: ch3 empties in RD after one word
        do_reset();
        base = mon_n; rd_base = mon_rd[3];
        for (int i = 0; i < 3; i++) push(3, 8'h31 + i);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && out_sop) break;
        end
        chk("t5.sop_seen", out_valid && out_sop, 1);
        @(posedge clk);
        #1 force_empty[3] = 1'b1;
        #1 chk("t5.no_rd", fifo_rd, 0);
        @(posedge clk);
        #1 chk("t5.abort_hi", abort, 1);
        chk("t5.idle", busy, 0);
        @(posedge clk);
        #1 chk("t5.abort_lo", abort, 0);
        chk("t5.words", mon_n - base, 1);
        chk("t5.word_eop", mon_eop[base], 0);
        chk("t5.rd_pulses", mon_rd[3] - rd_base, 1);

        // Asynchronous reset in RD, WAIT and OUT
        for (int p = 1; p <= 3; p++) begin
            do_reset();
            push(2, 8'h5A);
            repeat (p) @(posedge clk);
            #2 chk($sformatf("t6.p%0d.busy_pre", p), busy, 1);
            if (p == 1) chk("t6.rd_pre", fifo_rd, 4'b0100);
            if (p == 3) chk("t6.valid_pre", out_valid, 1);
            rst = 1'b1;
            #1 chk($sformatf("t6.p%0d.rd", p), fifo_rd, 0);
            chk($sformatf("t6.p%0d.valid", p), out_valid, 0);
            chk($sformatf("t6.p%0d.busy", p), busy, 0);
        end

        // Channel-0 priority vs. alternation, granted channel refilled each time
        do_reset();
`ifdef FIFO_ARB_PRIO0_EN
        grant_exp = '{0, 0, 0, 0};
`else
        grant_exp = '{0, 1, 0, 1};
`endif
        push(0, 8'hE0);
        push(1, 8'hF0);
        for (int g = 0; g < 4; g++) begin
            grant_ch = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (out_valid && out_sop) begin
                    grant_ch = int'(out_ch);
                    break;
                end
            end
            chk($sformatf("t7.grant%0d", g), grant_ch, grant_exp[g]);
            if (grant_ch >= 0) push(grant_ch, 8'hE1 + g);
            @(posedge clk);
        end

        // Global invariants over the whole run
        chk("rd_onehot_no_valid", n_viol, 0);
        chk("idle_gap", n_gap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
